// File: rtl/fp16_result_packer.sv
// Packs an unpacked FP add/sub result (sign, mantissa with hidden bit, widened biased exponent)
// into an IEEE-754 binary16 word. Define FP16_PACK_SUBNORM_EN for serial subnormal generation.
module fp16_result_packer #(
    parameter int MANT_W    = 11,
    parameter int EXP_W     = 5,
    parameter int EXP_IN_W  = 7,
    parameter int MAX_SHIFT = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sign,
    input  logic [MANT_W-1:0]   in_mant,
    input  logic [EXP_IN_W-1:0] in_exp,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [15:0]         out_word,
    output logic                out_ovf,
    output logic                out_unf,
    output logic                out_inv
);

    localparam int FRAC_W = MANT_W - 1;
    localparam logic signed [EXP_IN_W-1:0] EXP_OVF = EXP_IN_W'((1 << EXP_W) - 1);
    localparam logic signed [EXP_IN_W-1:0] EXP_ONE = EXP_IN_W'(1);

`ifdef FP16_PACK_SUBNORM_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`else
    typedef enum logic {IDLE = 1'b0, DONE = 1'b1} state_t;
`endif

    typedef enum logic [2:0] {C_ZERO, C_INV, C_OVF, C_NORM, C_SUB} cls_t;

    state_t state;
    cls_t   cls;

    logic signed [EXP_IN_W-1:0] exp_s;
    assign exp_s = $signed(in_exp);

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        cls = C_SUB;
        if (in_mant == '0)
            cls = C_ZERO;
        else if (!in_mant[MANT_W-1])
            cls = C_INV;
        else if (exp_s >= EXP_OVF)
            cls = C_OVF;
        else if (exp_s >= EXP_ONE)
            cls = C_NORM;
    end

`ifdef FP16_PACK_SUBNORM_EN
    localparam int CNT_W = $clog2(MAX_SHIFT + 1);
    localparam logic [EXP_IN_W:0] SHIFT_CAP = (EXP_IN_W + 1)'(MAX_SHIFT);

    logic [EXP_IN_W:0] shift_raw;
    logic [CNT_W-1:0]  shift_n;
    logic [CNT_W-1:0]  cnt;
    logic [MANT_W-1:0] mant_q;
    logic [MANT_W-1:0] mant_nxt;
    logic              sign_q;

    // Only meaningful for exp <= 0, where 1 - exp is a positive count up to 65.
    assign shift_raw = (EXP_IN_W + 1)'(1) - (EXP_IN_W + 1)'(exp_s);
    assign shift_n   = (shift_raw >= SHIFT_CAP) ? CNT_W'(MAX_SHIFT) : shift_raw[CNT_W-1:0];
    assign mant_nxt  = mant_q >> 1;
`endif

    assign in_ready = (state == IDLE);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_word  <= '0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
            out_inv   <= 1'b0;
`ifdef FP16_PACK_SUBNORM_EN
            cnt       <= '0;
            mant_q    <= '0;
            sign_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        out_ovf   <= 1'b0;
                        out_unf   <= 1'b0;
                        out_inv   <= 1'b0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                        case (cls)
                            C_ZERO: out_word <= '0;
                            C_INV: begin
                                out_word <= {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
                                out_inv  <= 1'b1;
                            end
                            C_OVF: begin
                                out_word <= {in_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                                out_ovf  <= 1'b1;
                            end
                            C_NORM: out_word <= {in_sign, in_exp[EXP_W-1:0], in_mant[FRAC_W-1:0]};
                            default: begin
`ifdef FP16_PACK_SUBNORM_EN
                                state     <= SHIFT;
                                out_valid <= 1'b0;
                                sign_q    <= in_sign;
                                mant_q    <= in_mant;
                                cnt       <= shift_n;
`else
                                out_word  <= {in_sign, {(EXP_W+FRAC_W){1'b0}}};
                                out_unf   <= 1'b1;
`endif
                            end
                        endcase
                    end
                end
`ifdef FP16_PACK_SUBNORM_EN
                SHIFT: begin
                    mant_q <= mant_nxt;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_word  <= {sign_q, {EXP_W{1'b0}}, mant_nxt[FRAC_W-1:0]};
                        out_unf   <= 1'b1;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
